noc_ni_tx: RTL and testbench

- Network-interface transmitter at a router's local port (port 4). It is the injection end of the local-port flit/credit protocol.
- Packetizes messages from a core into head/body/tail flits and selects a VC per packet.
- Tracks per-VC downstream credits for the router's local input buffers.
- Drives the router local inport and consumes the router's local-port per-VC credit returns.

---
 rtl/noc_ni_tx.sv | 184 ++++++++++++++++++
 tb/tb_noc_ni_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ni_tx.sv
// Local-port NI transmitter: packetizes core messages into flits with per-VC credits.
// Optional NI_TX_STATS_EN adds pkt_cnt/flit_cnt/stall_cnt counters.
module noc_ni_tx #(
  parameter int NUM_VCS   = 4,
  parameter int VC_BITS   = 2,
  parameter int DIM_BITS  = 3,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4,
  parameter int LEN_BITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIM_BITS-1:0]       my_x,
  input  logic [DIM_BITS-1:0]       my_y,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [DIM_BITS-1:0]       msg_dst_x,
  input  logic [DIM_BITS-1:0]       msg_dst_y,
  input  logic [LEN_BITS-1:0]       msg_len,
  input  logic                      pld_valid,
  output logic                      pld_ready,
  input  logic [DATA_W-1:0]         pld_data,
  output logic [4+VC_BITS+DATA_W-1:0] out_flit,
  input  logic [NUM_VCS-1:0]        credit_in,
  output logic                      credit_err
`ifdef NI_TX_STATS_EN
  ,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               flit_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int FW = 4 + VC_BITS + DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  logic [1:0]          r_state;
  logic [DIM_BITS-1:0] r_dx;
  logic [DIM_BITS-1:0] r_dy;
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] r_idx;
  logic [VC_BITS-1:0]  r_vc;
  logic [VC_BITS-1:0]  r_rr;
  logic [CW-1:0]       r_cnt [NUM_VCS];
  logic                r_err;
  logic [FW-1:0]       r_flit;

  logic                w_found;
  logic [VC_BITS-1:0]  w_sel;
  logic                w_pld_ok;
  logic                w_hd_go;
  logic                w_bd_go;
  logic                w_last;
  logic [NUM_VCS-1:0]  w_send;
  logic [DATA_W-1:0]   w_hdr;

  // Descending scan so the VC closest to rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_VCS - 1; i >= 0; i--) begin
      if (r_cnt[VC_BITS'(r_rr + VC_BITS'(i))] != '0) begin
        w_found = 1'b1;
        w_sel   = VC_BITS'(r_rr + VC_BITS'(i));
      end
    end
  end

  assign w_pld_ok  = (r_cnt[r_vc] != '0);
  assign msg_ready = !rst && (r_state == S_IDLE);
  assign pld_ready = !rst && (r_state == S_BODY) && w_pld_ok;
  assign w_hd_go   = (r_state == S_HEAD) && w_found;
  assign w_bd_go   = pld_valid && pld_ready;
  assign w_last    = (r_idx == LEN_BITS'(r_len - 1'b1));
  assign w_hdr     = DATA_W'({r_len, my_y, my_x, r_dy, r_dx});

  always_comb begin
    w_send = '0;
    if (w_hd_go)
      w_send[w_sel] = 1'b1;
    else if (w_bd_go)
      w_send[r_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dx    <= '0;
      r_dy    <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_vc    <= '0;
      r_rr    <= '0;
      r_err   <= 1'b0;
      r_flit  <= '0;
      for (int v = 0; v < NUM_VCS; v++)
        r_cnt[v] <= CW'(BUF_DEPTH);
    end else begin
      r_flit <= '0;
      case (r_state)
        S_IDLE: begin
          if (msg_valid) begin
            r_dx    <= msg_dst_x;
            r_dy    <= msg_dst_y;
            r_len   <= msg_len;
            r_idx   <= '0;
            r_state <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (w_found) begin
            r_flit  <= {1'b1, 1'b1, (r_len == '0), 1'b0,
                        w_sel, w_hdr};
            r_vc    <= w_sel;
            r_rr    <= w_sel + 1'b1;
            r_state <= (r_len == '0) ? S_IDLE : S_BODY;
          end
        end
        S_BODY: begin
          if (w_bd_go) begin
            r_flit <= {1'b1, 1'b0, w_last, 1'b0,
                       r_vc, pld_data};
            r_idx  <= r_idx + 1'b1;
            if (w_last)
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A return and a send on the same VC cancel out.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (credit_in[v] && !w_send[v]) begin
          if (r_cnt[v] == CW'(BUF_DEPTH))
            r_err <= 1'b1;
          else
            r_cnt[v] <= r_cnt[v] + 1'b1;
        end else if (w_send[v] && !credit_in[v]) begin
          r_cnt[v] <= r_cnt[v] - 1'b1;
        end
      end
    end
  end

  assign out_flit   = r_flit;
  assign credit_err = r_err;

`ifdef NI_TX_STATS_EN
  logic [31:0] r_pkt;
  logic [31:0] r_flt;
  logic [31:0] r_stl;
  logic        w_tail_go;
  logic        w_stall;

  assign w_tail_go = (w_hd_go && (r_len == '0)) ||
                     (w_bd_go && w_last);
  assign w_stall   = ((r_state == S_HEAD) && !w_found) ||
                     ((r_state == S_BODY) &&
                      (!w_pld_ok || !pld_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt <= '0;
      r_flt <= '0;
      r_stl <= '0;
    end else begin
      if (w_tail_go)
        r_pkt <= r_pkt + 1'b1;
      if (w_send != '0)
        r_flt <= r_flt + 1'b1;
      if (w_stall)
        r_stl <= r_stl + 1'b1;
    end
  end

  assign pkt_cnt   = r_pkt;
  assign flit_cnt  = r_flt;
  assign stall_cnt = r_stl;
`endif

endmodule

// File: tb/tb_noc_ni_tx.sv
// Scoreboard bench for noc_ni_tx: directed packets, credit stalls, reset abort.
// A negedge monitor pops expected flits and compares every valid output.
module tb_noc_ni_tx;

  typedef logic [37:0] flit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  my_x, my_y;
  logic        msg_valid;
  logic        msg_ready;
  logic [2:0]  msg_dst_x, msg_dst_y;
  logic [3:0]  msg_len;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] pld_data;
  flit_t       out_flit;
  logic [3:0]  credit_in;
  logic        credit_err;

  flit_t exp_q[$];
  int    fcyc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  noc_ni_tx dut (
    .clk(clk), .rst(rst), .my_x(my_x), .my_y(my_y),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_dst_x(msg_dst_x), .msg_dst_y(msg_dst_y),
    .msg_len(msg_len), .pld_valid(pld_valid),
    .pld_ready(pld_ready), .pld_data(pld_data),
    .out_flit(out_flit), .credit_in(credit_in),
    .credit_err(credit_err)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, expv);
    end
  endtask

  function automatic flit_t mk(logic h, logic t,
                               logic [1:0] vc,
                               logic [31:0] d);
    return {1'b1, h, t, 1'b0, vc, d};
  endfunction

  function automatic logic [31:0] hdr(logic [2:0] dx,
                                      logic [2:0] dy,
                                      logic [3:0] len);
    return {16'h0, len, my_y, my_x, dy, dx};
  endfunction

  always @(negedge clk) begin : monitor
    flit_t e;
    if (out_flit[37] === 1'b1) begin
      fcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_flit: got %0h expected none",
                 out_flit);
      end else begin
        e = exp_q.pop_front();
        chk("flit", out_flit, e);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; msg_valid = 1'b0;
    pld_valid = 1'b0; credit_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_msg(input logic [2:0] dx,
                          input logic [2:0] dy,
                          input logic [3:0] len,
                          output int tacc);
    @(posedge clk); #1;
    msg_valid = 1'b1; msg_dst_x = dx;
    msg_dst_y = dy; msg_len = len;
    tacc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (msg_ready) begin
        tacc = cyc;
        break;
      end
    end
    chk("msg_accept", (tacc >= 0), 1);
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic [31:0] base);
    bit ok;
    pld_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      pld_data = base + i;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (pld_ready) ok = 1;
        @(posedge clk); #1;
        if (ok) break;
      end
      chk("pld_accept", ok, 1);
    end
    pld_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0;
    rst = 1'b1; my_x = 3'd0; my_y = 3'd0;
    msg_valid = 1'b0; msg_dst_x = '0; msg_dst_y = '0;
    msg_len = '0; pld_valid = 1'b0; pld_data = '0;
    credit_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_pld_ready", pld_ready, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_cnt0", dut.r_cnt[0], 4);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_msg_ready", msg_ready, 1);

    // single-flit packet, head latency
    exp_q.push_back(mk(1, 1, 0, 32'h0000_000A));
    send_msg(3'd2, 3'd1, 4'd0, t);
    repeat (3) @(negedge clk);
    chk("hd_latency", fcyc[fcyc.size()-1] - t, 2);
    chk("cnt0_after_1", dut.r_cnt[0], 3);

    // len-3 packet streamed every cycle
    my_x = 3'd3; my_y = 3'd5;
    do_reset();
    exp_q.push_back(mk(1, 0, 0, hdr(3'd1, 3'd1, 4'd3)));
    exp_q.push_back(mk(0, 0, 0, 32'hA0));
    exp_q.push_back(mk(0, 0, 0, 32'hA1));
    exp_q.push_back(mk(0, 1, 0, 32'hA2));
    send_msg(3'd1, 3'd1, 4'd3, t);
    stream(3, 32'hA0);
    repeat (3) @(negedge clk);
    chk("body_back2back",
        fcyc[fcyc.size()-1] - fcyc[fcyc.size()-4], 3);
    chk("cnt0_drained", dut.r_cnt[0], 0);

    // round robin until all credits are spent
    do_reset();
    for (int p = 0; p < 16; p++) begin
      exp_q.push_back(mk(1, 1, 2'(p % 4),
                         hdr(3'd1, 3'd2, 4'd0)));
      send_msg(3'd1, 3'd2, 4'd0, t);
    end
    send_msg(3'd1, 3'd2, 4'd0, t);
    n0 = fcyc.size();
    repeat (10) @(negedge clk);
    chk("hold_no_flit", fcyc.size() - n0, 0);
    chk("hold_msg_ready", msg_ready, 0);
    exp_q.push_back(mk(1, 1, 2, hdr(3'd1, 3'd2, 4'd0)));
    @(posedge clk); #1 credit_in = 4'b0100;
    @(posedge clk); #1 credit_in = 4'b0000;
    repeat (5) @(negedge clk);
    chk("credited_vc_sent", exp_q.size(), 0);

    // body stall on credits, same-cycle credit and send
    do_reset();
    exp_q.push_back(mk(1, 0, 0, hdr(3'd4, 3'd4, 4'd6)));
    for (int i = 0; i < 6; i++)
      exp_q.push_back(mk(0, (i == 5), 0, 32'h100 + i));
    n0 = fcyc.size();
    send_msg(3'd4, 3'd4, 4'd6, t);
    fork
      stream(6, 32'h100);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (fcyc.size() >= n0 + 4) break;
        end
        chk("stall_flits", fcyc.size() >= n0 + 4, 1);
        chk("stall_ready", pld_ready, 0);
        chk("stall_cnt0", dut.r_cnt[0], 0);
        repeat (2) @(negedge clk);
        chk("stall_hold", pld_ready, 0);
        @(posedge clk); #1 credit_in = 4'b0001;
        @(negedge clk);
        chk("credit_cycle_ready", pld_ready, 0);
        @(posedge clk); #1 credit_in = 4'b0001;
        @(negedge clk);
        chk("credit_next_ready", pld_ready, 1);
        @(posedge clk); #1 credit_in = 4'b0000;
        @(negedge clk);
        chk("same_cycle_ready", pld_ready, 1);
        chk("same_cycle_cnt", dut.r_cnt[0], 1);
        @(negedge clk);
        chk("restall_ready", pld_ready, 0);
        @(posedge clk); #1 credit_in = 4'b0001;
        @(posedge clk); #1 credit_in = 4'b0000;
      end
    join
    repeat (3) @(negedge clk);
    chk("stall_pkt_done", exp_q.size(), 0);

    // overflow credit on an idle VC
    @(negedge clk);
    chk("err_before", credit_err, 0);
    @(posedge clk); #1 credit_in = 4'b0010;
    @(posedge clk); #1 credit_in = 4'b0000;
    @(negedge clk);
    chk("err_set", credit_err, 1);
    chk("err_cnt1", dut.r_cnt[1], 4);
    repeat (5) @(negedge clk);
    chk("err_sticky", credit_err, 1);

    // reset in the middle of a len-5 packet
    do_reset();
    @(negedge clk);
    chk("err_cleared", credit_err, 0);
    exp_q.push_back(mk(1, 0, 0, hdr(3'd2, 3'd3, 4'd5)));
    exp_q.push_back(mk(0, 0, 0, 32'h200));
    exp_q.push_back(mk(0, 0, 0, 32'h201));
    send_msg(3'd2, 3'd3, 4'd5, t);
    stream(2, 32'h200);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out", out_flit, 0);
    chk("abort_cnt0", dut.r_cnt[0], 4);
    chk("abort_msg_ready", msg_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", msg_ready, 1);
    exp_q.push_back(mk(1, 1, 0, hdr(3'd7, 3'd7, 4'd0)));
    send_msg(3'd7, 3'd7, 4'd0, t);
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
